// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver with clock glitch filter, frame timeout and a
// show-ahead FIFO drained through a valid/ready pop interface.
module ps2_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int T_TIMEOUT  = 100000,
    parameter int FILTER_LEN = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CLK_MOUSE_IN,
    input  logic                 DATA_MOUSE_IN,
    input  logic                 READ_ENABLE,
    input  logic                 RX_READY,
    input  logic                 CLEAR_FLAGS,
    output logic                 RX_VALID,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic [1:0]           RX_ERR,
    output logic [FIFO_AW:0]     FIFO_COUNT,
    output logic                 OVERFLOW,
    output logic                 TIMEOUT_PULSE,
    output logic [1:0]           RX_STATE
);

    // Pop handshake: an entry leaves the FIFO on a CLK edge where RX_VALID and RX_READY
    // are both high; RX_DATA/RX_ERR are valid whenever RX_VALID is high.

    localparam int FCW     = $clog2(FILTER_LEN + 1);
    localparam int BCW     = $clog2(DATA_BITS + 1);
    localparam int TW      = $clog2(T_TIMEOUT + 1);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [FCW-1:0]   FLT_LAST  = FCW'(FILTER_LEN - 1);
    localparam logic [BCW-1:0]   BIT_LAST  = BCW'(DATA_BITS - 1);
    localparam logic [TW-1:0]    TIMER_MAX = TW'(T_TIMEOUT);
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           clk_filt;
    logic [FCW-1:0] flt_cnt;
    logic           fall;

    state_t state, state_next;

    logic                 start_bit, shift_en, parity_en, stop_en, timer_exp;
    logic [BCW-1:0]       bit_ctr;
    logic [DATA_BITS-1:0] shift;
    logic [TW-1:0]        timer;
    logic                 perr;
    logic                 push_q;
    logic [ENTRY_W-1:0]   push_entry;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               fifo_full, do_pop, do_wr;

    // Synchronisers and glitch filter; fall is registered alongside the filtered edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s1 <= CLK_MOUSE_IN;
            clk_s2 <= clk_s1;
            dat_s1 <= DATA_MOUSE_IN;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 != clk_filt) begin
                if (flt_cnt == FLT_LAST) begin
                    clk_filt <= clk_s2;
                    flt_cnt  <= '0;
                    fall     <= clk_filt;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    assign timer_exp = (state != ST_IDLE) && (timer == TIMER_MAX);

    // Timeout has priority over a coincident fall.
    always_comb begin
        state_next = state;
        if (timer_exp) begin
            state_next = ST_IDLE;
        end else if (fall) begin
            case (state)
                ST_IDLE:   if (READ_ENABLE && !dat_s2) state_next = ST_DATA;
                ST_DATA:   if (bit_ctr == BIT_LAST) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start_bit = 1'b0;
        shift_en  = 1'b0;
        parity_en = 1'b0;
        stop_en   = 1'b0;
        if (fall && !timer_exp) begin
            case (state)
                ST_IDLE:   start_bit = READ_ENABLE && !dat_s2;
                ST_DATA:   shift_en  = 1'b1;
                ST_PARITY: parity_en = 1'b1;
                ST_STOP:   stop_en   = 1'b1;
                default:   start_bit = 1'b0;
            endcase
        end
    end

    assign RX_STATE = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_ctr       <= '0;
            shift         <= '0;
            timer         <= '0;
            perr          <= 1'b0;
            push_q        <= 1'b0;
            push_entry    <= '0;
            TIMEOUT_PULSE <= 1'b0;
        end else begin
            push_q        <= 1'b0;
            TIMEOUT_PULSE <= timer_exp;
            if (start_bit) begin
                bit_ctr <= '0;
                shift   <= '0;
                timer   <= '0;
            end else if (state != ST_IDLE) begin
                if (fall)                   timer <= '0;
                else if (timer != TIMER_MAX) timer <= timer + 1'b1;
            end
            if (shift_en) begin
                shift   <= {dat_s2, shift[DATA_BITS-1:1]};
                bit_ctr <= bit_ctr + 1'b1;
            end
            if (parity_en) perr <= (dat_s2 != ~^shift);
            if (stop_en) begin
                push_q     <= 1'b1;
                push_entry <= {~dat_s2, perr, shift};
            end
        end
    end

    assign fifo_full = (FIFO_COUNT == FULL_CNT);
    assign RX_VALID  = (FIFO_COUNT != '0);
    assign do_pop    = RX_VALID && RX_READY;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_wr     = push_q && (!fifo_full || do_pop);

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_COUNT <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   FIFO_COUNT <= FIFO_COUNT + 1'b1;
                2'b01:   FIFO_COUNT <= FIFO_COUNT - 1'b1;
                default: FIFO_COUNT <= FIFO_COUNT;
            endcase
            if (push_q && fifo_full && !do_pop) OVERFLOW <= 1'b1;
            else if (CLEAR_FLAGS)               OVERFLOW <= 1'b0;
        end
    end

    assign RX_DATA = RX_VALID ? mem[rd_ptr][DATA_BITS-1:0] : '0;
    assign RX_ERR  = RX_VALID ? mem[rd_ptr][ENTRY_W-1:DATA_BITS] : 2'b00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames are driven on the pins and FIFO output,
// flags and debug state are compared against hand-computed values.
module tb_ps2_rx_fifo;

    localparam int DB  = 8;
    localparam int TT  = 200;
    localparam int FL  = 4;
    localparam int FAW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ps2_clk, ps2_dat;
    logic          read_enable, rx_ready, clear_flags;
    logic          rx_valid;
    logic [DB-1:0] rx_data;
    logic [1:0]    rx_err;
    logic [FAW:0]  fifo_count;
    logic          overflow, timeout_pulse;
    logic [1:0]    rx_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DATA_BITS(DB), .T_TIMEOUT(TT), .FILTER_LEN(FL), .FIFO_AW(FAW)
    ) dut (
        .CLK(clk), .RESET(reset),
        .CLK_MOUSE_IN(ps2_clk), .DATA_MOUSE_IN(ps2_dat),
        .READ_ENABLE(read_enable), .RX_READY(rx_ready), .CLEAR_FLAGS(clear_flags),
        .RX_VALID(rx_valid), .RX_DATA(rx_data), .RX_ERR(rx_err),
        .FIFO_COUNT(fifo_count), .OVERFLOW(overflow),
        .TIMEOUT_PULSE(timeout_pulse), .RX_STATE(rx_state)
    );

    // One PS/2 bit: data set up, clock low 10 cycles, high 5. With pop set, RX_READY
    // is raised for exactly the cycle in which the stop-bit push reaches the FIFO.
    task automatic send_bit(input logic b, input bit pop);
        @(negedge clk) ps2_dat = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop) begin
            repeat (7) @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk) rx_ready = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stp,
                              input int glitch_at, input bit pop_at_push);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < DB; i++) begin
            send_bit(d[i], 1'b0);
            if (i == glitch_at) begin
                ps2_clk = 1'b0;
                repeat (FL - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
        send_bit(par, 1'b0);
        send_bit(stp, pop_at_push);
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        n_checks++; if ({overflow, timeout_pulse, rx_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {overflow, timeout_pulse, rx_err}); end
        n_checks++; if (rx_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", rx_state); end
    endtask

    task automatic test_basic_frame();
        send_frame(8'hFA, 1'b1, 1'b1, -1, 1'b0);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL fa_valid got %b exp 1", rx_valid); end
        n_checks++; if (rx_data !== 8'hFA) begin n_fail++; $display("FAIL fa_data got %h exp fa", rx_data); end
        n_checks++; if (rx_err !== 2'b00) begin n_fail++; $display("FAIL fa_err got %b exp 00", rx_err); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL fa_count got %0d exp 1", fifo_count); end
        pop_one();
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL fa_pop_count got %0d exp 0", fifo_count); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL fa_pop_valid got %b exp 0", rx_valid); end
    endtask

    task automatic test_errors();
        send_frame(8'h08, 1'b1, 1'b1, -1, 1'b0);
        n_checks++; if (rx_data !== 8'h08) begin n_fail++; $display("FAIL perr_data got %h exp 08", rx_data); end
        n_checks++; if (rx_err !== 2'b01) begin n_fail++; $display("FAIL perr_err got %b exp 01", rx_err); end
        pop_one();
        send_frame(8'h08, 1'b0, 1'b0, -1, 1'b0);
        n_checks++; if (rx_data !== 8'h08) begin n_fail++; $display("FAIL serr_data got %h exp 08", rx_data); end
        n_checks++; if (rx_err !== 2'b10) begin n_fail++; $display("FAIL serr_err got %b exp 10", rx_err); end
        pop_one();
    endtask

    task automatic test_glitch();
        send_frame(8'hA5, 1'b1, 1'b1, 3, 1'b0);
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL glitch_count got %0d exp 1", fifo_count); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL glitch_data got %h exp a5", rx_data); end
        n_checks++; if (rx_err !== 2'b00) begin n_fail++; $display("FAIL glitch_err got %b exp 00", rx_err); end
        pop_one();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        n_checks++; if (rx_state !== 2'd1) begin n_fail++; $display("FAIL to_mid_state got %0d exp 1", rx_state); end
        for (int c = 0; c < TT + 10; c++) begin
            @(negedge clk);
            if (timeout_pulse === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL to_pulses got %0d exp 1", pulses); end
        n_checks++; if (rx_state !== 2'd0) begin n_fail++; $display("FAIL to_state got %0d exp 0", rx_state); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL to_count got %0d exp 0", fifo_count); end
        send_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0);
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL to_next_data got %h exp 3c", rx_data); end
        n_checks++; if (rx_err !== 2'b00) begin n_fail++; $display("FAIL to_next_err got %b exp 00", rx_err); end
        pop_one();
    endtask

    task automatic test_reset_midframe();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        n_checks++; if (rx_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got %0d exp 0", rx_state); end
        repeat (30) @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d exp 0", fifo_count); end
    endtask

    task automatic test_overflow();
        logic [DB-1:0] vals [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic          pars [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) send_frame(vals[i], pars[i], 1'b1, -1, 1'b0);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rx_data !== vals[i]) begin n_fail++; $display("FAIL ovf_pop%0d got %h exp %h", i, rx_data, vals[i]); end
            n_checks++; if (rx_err !== 2'b00) begin n_fail++; $display("FAIL ovf_err%0d got %b exp 00", i, rx_err); end
            pop_one();
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b exp 0", rx_valid); end
        pop_one();
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_pop_empty got %0d exp 0", fifo_count); end
        @(negedge clk) clear_flags = 1'b1;
        @(negedge clk) clear_flags = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [DB-1:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) send_frame(vals[i], ~^vals[i], 1'b1, -1, 1'b0);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fpp_fill got %0d exp 4", fifo_count); end
        send_frame(vals[4], ~^vals[4], 1'b1, -1, 1'b1);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fpp_count got %0d exp 4", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
        read_enable = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, -1, 1'b0);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL re0_count got %0d exp 4", fifo_count); end
        n_checks++; if (rx_state !== 2'd0) begin n_fail++; $display("FAIL re0_state got %0d exp 0", rx_state); end
        read_enable = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (rx_data !== vals[i]) begin n_fail++; $display("FAIL fpp_pop%0d got %h exp %h", i, rx_data, vals[i]); end
            pop_one();
        end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL fpp_drain got %0d exp 0", fifo_count); end
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        read_enable = 1'b1; rx_ready = 1'b0; clear_flags = 1'b0;
        test_reset();
        test_basic_frame();
        test_errors();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        test_overflow();
        test_full_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
